neuron_update_scheduler: RTL and testbench
==========================================

// Module: neuron_update_scheduler
// PURPOSE
//  Per-timestep sequencer for the neuron potential datapath. For each neuron 0..neuron_count-1 it
//  reads the stored potential, starts the accumulate adder, and samples the spike flag and reset
//  unit result. It writes potential_to_mem back to potential memory and emits a spike event for
//  each neuron that fired. It sits between potential memory, the adder/reset units and the spike
//  output network.
// PARAMETERS
//  N_MAX      256  maximum neurons per timestep; sets IDX_W = clog2(N_MAX)
//  READ_LAT   1    cycles from the mem_rd_en pulse to valid mem_rd_data (>=1)
//  TIMEOUT    64   maximum cycles to wait for adder_done before raising Exception
// PORTS
//  CLK              in   1      clock, rising edge
//  RESET            in   1      asynchronous, active-high reset
//  timestep_start   in   1      pulse: begin an update sweep (ignored while busy)
//  neuron_count     in   IDX_W+1 neurons to update, sampled on accepted timestep_start
//  busy             out  1      high from accept until the timestep_done cycle
//  timestep_done    out  1      1-cycle pulse when the sweep completes
//  mem_addr         out  IDX_W  neuron index for both read and write
//  mem_rd_en        out  1      1-cycle read strobe
//  mem_rd_data      in   32     stored potential (IEEE-754 single)
//  mem_wr_en        out  1      1-cycle write strobe
//  mem_wr_data      out  32     registered copy of potential_to_mem
//  adder_start      out  1      1-cycle pulse; adder operand is adder_operand
//  adder_operand    out  32     potential latched from mem_rd_data
//  adder_done       in   1      adder result valid; spiked/potential_to_mem valid same cycle
//  spiked           in   1      threshold-comparison result for the current neuron
//  potential_to_mem in   32     reset unit output (reset or passed-through potential)
//  spike_valid      out  1      spike event valid
//  spike_id         out  IDX_W  index of the neuron that spiked
//  spike_ready      in   1      downstream accepts the event when valid&ready
//  Exception        out  1      sticky: adder timeout; cleared only by RESET
// BEHAVIOUR
//  - RESET (at any time, including mid-sweep): state=IDLE; all outputs 0; idx=0; counters=0.
//  - States:
//      IDLE -> RD on timestep_start when neuron_count!=0.
//              With neuron_count==0: no memory access; timestep_done pulses next cycle; busy stays 0.
//      RD   : mem_rd_en=1, mem_addr=idx for one cycle -> WAIT
//      WAIT : count READ_LAT cycles; on the last cycle latch mem_rd_data into adder_operand -> ADD
//      ADD  : adder_start=1 for one cycle -> ACC
//      ACC  : wait for adder_done. When it arrives, latch spiked and potential_to_mem -> WB.
//             If the wait reaches TIMEOUT cycles: set Exception and go -> FIN, skipping remaining neurons.
//      WB   : mem_wr_en=1, mem_addr=idx, mem_wr_data=latched potential -> SPK if spiked, else NXT
//      SPK  : hold spike_valid=1, spike_id=idx until spike_ready. No timeout (backpressure allowed).
//             -> NXT on the cycle valid&ready.
//      NXT  : if idx==neuron_count-1 -> FIN; else idx++ -> RD
//      FIN  : timestep_done=1, busy=0 for one cycle; idx=0 -> IDLE
//  - Per-neuron latency without spike: 5+READ_LAT cycles (RD, WAIT, ADD, ACC(min 1), WB, NXT).
//    Add 1+ cycles for SPK.
//  - busy=1 in every state except IDLE and FIN.
//  - timestep_start while busy is ignored and not queued. neuron_count is clamped to N_MAX.
//  - adder_done outside ACC is ignored. Strobes are never asserted simultaneously.
//  - mem_addr holds its last value between strobes.
// TESTING
//  1 neuron_count=3, mem = {0x40000000, 0x40400000, 0x41000000}, adder +1.0, spiked=0 ->
//    3 writes {0x40400000, 0x40800000, 0x41100000}; no spikes; done pulse once; busy low after.
//  2 neuron_count=1, adder result 0x41780000, spiked=1, potential_to_mem=0 ->
//    write 0x00000000 to addr 0; spike_id=0; hold spike_valid 4 cycles with spike_ready=0,
//    then accept; done follows.
//  3 neuron_count=0 -> no rd/wr strobes; timestep_done pulses the cycle after start.
//  4 adder_done never asserted -> Exception=1 after 64 ACC cycles; FIN reached; no write;
//    Exception stays 1 through the next sweep.
//  5 RESET pulsed during SPK of neuron 2 of 4 -> all outputs 0 within reset.
//    A new start then sweeps from idx 0.
//  6 timestep_start re-pulsed mid-sweep, READ_LAT=3 -> ignored; exactly neuron_count writes;
//    per-neuron latency 8 cycles.

Source files
------------

// File: rtl/neuron_update_scheduler.sv
// Per-timestep sweep sequencer for the neuron potential datapath: read, accumulate,
// write back and emit spike events for neurons 0..neuron_count-1.
module neuron_update_scheduler #(
    parameter int N_MAX    = 256,
    parameter int READ_LAT = 1,
    parameter int TIMEOUT  = 64,
    localparam int IDX_W   = $clog2(N_MAX)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             timestep_start,
    input  logic [IDX_W:0]   neuron_count,
    output logic             busy,
    output logic             timestep_done,
    output logic [IDX_W-1:0] mem_addr,
    output logic             mem_rd_en,
    input  logic [31:0]      mem_rd_data,
    output logic             mem_wr_en,
    output logic [31:0]      mem_wr_data,
    output logic             adder_start,
    output logic [31:0]      adder_operand,
    input  logic             adder_done,
    input  logic             spiked,
    input  logic [31:0]      potential_to_mem,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_id,
    input  logic             spike_ready,
    output logic             Exception
);

    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   N_MAX_W  = (IDX_W+1)'(N_MAX);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_ADD,
        S_ACC,
        S_WB,
        S_SPK,
        S_NXT,
        S_FIN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   count_q;
    logic [LAT_W-1:0] wait_cnt;
    logic [TO_W-1:0]  acc_cnt;
    logic             spk_q;

    logic [IDX_W:0]   count_clamped;
    logic             last_neuron;

    assign count_clamped = (neuron_count > N_MAX_W) ? N_MAX_W : neuron_count;
    assign last_neuron   = ({1'b0, idx} == (count_q - CNT_ONE));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            idx           <= '0;
            count_q       <= '0;
            wait_cnt      <= '0;
            acc_cnt       <= '0;
            spk_q         <= 1'b0;
            busy          <= 1'b0;
            timestep_done <= 1'b0;
            mem_addr      <= '0;
            mem_rd_en     <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_wr_data   <= '0;
            adder_start   <= 1'b0;
            adder_operand <= '0;
            spike_valid   <= 1'b0;
            spike_id      <= '0;
            Exception     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (timestep_start) begin
                        if (neuron_count == '0) begin
                            // Empty sweep: report completion without touching memory.
                            timestep_done <= 1'b1;
                            state         <= S_FIN;
                        end else begin
                            count_q   <= count_clamped;
                            idx       <= '0;
                            mem_addr  <= '0;
                            mem_rd_en <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    mem_rd_en <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        adder_operand <= mem_rd_data;
                        adder_start   <= 1'b1;
                        state         <= S_ADD;
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end
                S_ADD: begin
                    adder_start <= 1'b0;
                    acc_cnt     <= '0;
                    state       <= S_ACC;
                end
                S_ACC: begin
                    if (adder_done) begin
                        spk_q       <= spiked;
                        mem_wr_data <= potential_to_mem;
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= idx;
                        state       <= S_WB;
                    end else if (acc_cnt == TO_LAST) begin
                        // A hung adder abandons the rest of the sweep.
                        Exception     <= 1'b1;
                        busy          <= 1'b0;
                        timestep_done <= 1'b1;
                        state         <= S_FIN;
                    end else begin
                        acc_cnt <= acc_cnt + TO_W'(1);
                    end
                end
                S_WB: begin
                    mem_wr_en <= 1'b0;
                    if (spk_q) begin
                        spike_valid <= 1'b1;
                        spike_id    <= idx;
                        state       <= S_SPK;
                    end else begin
                        state <= S_NXT;
                    end
                end
                S_SPK: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        state       <= S_NXT;
                    end
                end
                S_NXT: begin
                    if (last_neuron) begin
                        busy          <= 1'b0;
                        timestep_done <= 1'b1;
                        state         <= S_FIN;
                    end else begin
                        idx       <= idx + IDX_ONE;
                        mem_addr  <= idx + IDX_ONE;
                        mem_rd_en <= 1'b1;
                        state     <= S_RD;
                    end
                end
                S_FIN: begin
                    timestep_done <= 1'b0;
                    idx           <= '0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Scoreboard bench for neuron_update_scheduler with a 3-cycle memory model and a
// table-driven accumulate adder.
module tb_neuron_update_scheduler;

    localparam int N_MAX    = 256;
    localparam int READ_LAT = 3;
    localparam int TIMEOUT  = 64;
    localparam int IDX_W    = $clog2(N_MAX);

    logic             CLK;
    logic             RESET;
    logic             timestep_start;
    logic [IDX_W:0]   neuron_count;
    logic             busy;
    logic             timestep_done;
    logic [IDX_W-1:0] mem_addr;
    logic             mem_rd_en;
    logic [31:0]      mem_rd_data;
    logic             mem_wr_en;
    logic [31:0]      mem_wr_data;
    logic             adder_start;
    logic [31:0]      adder_operand;
    logic             adder_done;
    logic             spiked;
    logic [31:0]      potential_to_mem;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_id;
    logic             spike_ready;
    logic             Exception;

    neuron_update_scheduler #(
        .N_MAX(N_MAX), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .timestep_start(timestep_start), .neuron_count(neuron_count),
        .busy(busy), .timestep_done(timestep_done),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .adder_start(adder_start), .adder_operand(adder_operand),
        .adder_done(adder_done), .spiked(spiked), .potential_to_mem(potential_to_mem),
        .spike_valid(spike_valid), .spike_id(spike_id), .spike_ready(spike_ready),
        .Exception(Exception)
    );

    typedef struct packed { logic [IDX_W-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic spk; logic [31:0] ptm; } add_t;

    wr_t              exp_wr[$];
    logic [31:0]      exp_op[$];
    logic [IDX_W-1:0] exp_spk[$];
    int               exp_done[$];
    add_t             add_q[$];
    int               rd_times[$];
    logic [IDX_W-1:0] rd_addrs[$];

    logic [31:0] mem [0:N_MAX-1];
    logic [31:0] rd_pipe [0:READ_LAT-1];
    logic        add_hang;
    int          cyc, n_cmp, n_bad, rd_cnt, wr_cnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory: data valid READ_LAT cycles after the strobe, garbage otherwise.
    always @(posedge CLK) begin
        rd_pipe[0] <= mem_rd_en ? mem[mem_addr] : 32'hDEADBEEF;
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[READ_LAT-1];

    // Adder + reset unit: responds the cycle after adder_start with the next table entry.
    always @(posedge CLK) begin
        adder_done <= 1'b0;
        if (adder_start && !add_hang) begin
            adder_done <= 1'b1;
            if (add_q.size() != 0) begin
                spiked           <= add_q[0].spk;
                potential_to_mem <= add_q[0].ptm;
                void'(add_q.pop_front());
            end else begin
                spiked           <= 1'b0;
                potential_to_mem <= 32'h0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge CLK) begin
        if (mem_rd_en | mem_wr_en | adder_start)
            chk("strobe_exclusive", 32'(mem_rd_en) + 32'(mem_wr_en) + 32'(adder_start), 32'd1);
        if (mem_rd_en) begin
            rd_cnt++;
            rd_times.push_back(cyc);
            rd_addrs.push_back(mem_addr);
        end
        if (adder_start) begin
            chk("op_expected", 32'(exp_op.size() != 0), 32'd1);
            if (exp_op.size() != 0) chk("adder_operand", adder_operand, exp_op.pop_front());
        end
        if (mem_wr_en) begin
            wr_cnt++;
            chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                chk("wr_addr", 32'(mem_addr), 32'(exp_wr[0].addr));
                chk("wr_data", mem_wr_data, exp_wr[0].data);
                void'(exp_wr.pop_front());
            end
        end
        if (spike_valid && spike_ready) begin
            chk("spk_expected", 32'(exp_spk.size() != 0), 32'd1);
            if (exp_spk.size() != 0) chk("spike_id", 32'(spike_id), 32'(exp_spk.pop_front()));
        end
        if (timestep_done) begin
            chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
            if (exp_done.size() != 0) void'(exp_done.pop_front());
            chk("busy_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_sweep(input int n);
        tick();
        timestep_start = 1'b1;
        neuron_count   = (IDX_W+1)'(n);
        tick();
        timestep_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k;
        k = 0;
        @(negedge CLK);
        while (!timestep_done && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk(nm, 32'(timestep_done), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"},  32'(busy), 32'd0);
        chk({nm, "_done"},  32'(timestep_done), 32'd0);
        chk({nm, "_addr"},  32'(mem_addr), 32'd0);
        chk({nm, "_strb"},  32'({mem_rd_en, mem_wr_en, adder_start, spike_valid}), 32'd0);
        chk({nm, "_wdata"}, mem_wr_data, 32'd0);
        chk({nm, "_op"},    adder_operand, 32'd0);
        chk({nm, "_sid"},   32'(spike_id), 32'd0);
        chk({nm, "_exc"},   32'(Exception), 32'd0);
    endtask

    task automatic chk_queues_empty(input string nm);
        chk({nm, "_wr_left"},   32'(exp_wr.size()), 32'd0);
        chk({nm, "_op_left"},   32'(exp_op.size()), 32'd0);
        chk({nm, "_spk_left"},  32'(exp_spk.size()), 32'd0);
        chk({nm, "_done_left"}, 32'(exp_done.size()), 32'd0);
    endtask

    initial begin
        repeat (20000) @(posedge CLK);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, rd0, wr0, k;
        cyc = 0; n_cmp = 0; n_bad = 0; rd_cnt = 0; wr_cnt = 0;
        RESET = 1'b1; timestep_start = 1'b0; neuron_count = '0;
        spike_ready = 1'b0; add_hang = 1'b0;
        for (int i = 0; i < N_MAX; i++) mem[i] = 32'h0;

        repeat (3) tick();
        chk_idle_outputs("reset");
        RESET = 1'b0;
        repeat (2) tick();

        // 1: three neurons, +1.0 each, no spikes.
        mem[0] = 32'h40000000; mem[1] = 32'h40400000; mem[2] = 32'h41000000;
        exp_op.push_back(32'h40000000); exp_op.push_back(32'h40400000); exp_op.push_back(32'h41000000);
        add_q.push_back('{1'b0, 32'h40400000});
        add_q.push_back('{1'b0, 32'h40800000});
        add_q.push_back('{1'b0, 32'h41100000});
        exp_wr.push_back('{8'd0, 32'h40400000});
        exp_wr.push_back('{8'd1, 32'h40800000});
        exp_wr.push_back('{8'd2, 32'h41100000});
        exp_done.push_back(1);
        start_sweep(3);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", 200);
        @(negedge CLK);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_done_single", 32'(timestep_done), 32'd0);
        chk("t1_no_spike", 32'(spike_valid), 32'd0);
        chk_queues_empty("t1");

        // 2: one neuron spikes; downstream stalls 4 cycles.
        mem[0] = 32'h41700000;
        exp_op.push_back(32'h41700000);
        add_q.push_back('{1'b1, 32'h00000000});
        exp_wr.push_back('{8'd0, 32'h00000000});
        exp_spk.push_back(8'd0);
        exp_done.push_back(1);
        start_sweep(1);
        k = 0;
        @(negedge CLK);
        while (!spike_valid && k < 100) begin @(negedge CLK); k++; end
        chk("t2_spike_valid", 32'(spike_valid), 32'd1);
        chk("t2_spike_id", 32'(spike_id), 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK);
            chk("t2_spike_hold", 32'({spike_valid, spike_id}), 32'h100);
            chk("t2_busy_hold", 32'(busy), 32'd1);
        end
        tick();
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;
        wait_done("t2_done", 10);
        @(negedge CLK);
        chk("t2_spike_dropped", 32'(spike_valid), 32'd0);
        chk_queues_empty("t2");

        // 3: empty sweep.
        rd0 = rd_cnt; wr0 = wr_cnt;
        exp_done.push_back(1);
        start_sweep(0);
        @(negedge CLK);
        chk("t3_done_next", 32'(timestep_done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        chk("t3_done_pulse", 32'(timestep_done), 32'd0);
        chk("t3_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("t3_no_wr", 32'(wr_cnt - wr0), 32'd0);

        // 4: adder never answers.
        add_hang = 1'b1;
        mem[0] = 32'h3F800000;
        exp_op.push_back(32'h3F800000);
        exp_done.push_back(1);
        wr0 = wr_cnt;
        start_sweep(1);
        k = 0;
        @(negedge CLK);
        while (!adder_start && k < 50) begin @(negedge CLK); k++; end
        chk("t4_adder_start", 32'(adder_start), 32'd1);
        t0 = cyc;
        k = 0;
        while (!Exception && k < 200) begin @(negedge CLK); k++; end
        chk("t4_exception", 32'(Exception), 32'd1);
        chk("t4_timeout_cycles", 32'(cyc - t0), 32'd65);
        chk("t4_fin_done", 32'(timestep_done), 32'd1);
        repeat (3) @(negedge CLK);
        chk("t4_no_wr", 32'(wr_cnt - wr0), 32'd0);
        chk("t4_exc_sticky", 32'(Exception), 32'd1);
        chk_queues_empty("t4");
        add_hang = 1'b0;

        // 6: restart request mid-sweep is dropped; 8-cycle pitch at READ_LAT=3.
        mem[0] = 32'h3F800000; mem[1] = 32'h40000000; mem[2] = 32'h40400000;
        exp_op.push_back(32'h3F800000); exp_op.push_back(32'h40000000); exp_op.push_back(32'h40400000);
        add_q.push_back('{1'b0, 32'h40000000});
        add_q.push_back('{1'b0, 32'h40400000});
        add_q.push_back('{1'b0, 32'h40800000});
        exp_wr.push_back('{8'd0, 32'h40000000});
        exp_wr.push_back('{8'd1, 32'h40400000});
        exp_wr.push_back('{8'd2, 32'h40800000});
        exp_done.push_back(1);
        rd_times.delete();
        rd0 = rd_cnt; wr0 = wr_cnt;
        start_sweep(3);
        repeat (9) tick();
        chk("t6_busy_at_repulse", 32'(busy), 32'd1);
        timestep_start = 1'b1;
        neuron_count   = 9'd5;
        tick();
        timestep_start = 1'b0;
        chk("t6_exc_during", 32'(Exception), 32'd1);
        wait_done("t6_done", 200);
        repeat (30) @(negedge CLK);
        chk("t6_rd_count", 32'(rd_cnt - rd0), 32'd3);
        chk("t6_wr_count", 32'(wr_cnt - wr0), 32'd3);
        if (rd_times.size() >= 3) begin
            chk("t6_pitch0", 32'(rd_times[1] - rd_times[0]), 32'd8);
            chk("t6_pitch1", 32'(rd_times[2] - rd_times[1]), 32'd8);
        end
        chk("t6_exc_after", 32'(Exception), 32'd1);
        chk_queues_empty("t6");

        // 5: reset lands while neuron 2 of 4 holds a spike.
        for (int i = 0; i < 4; i++) mem[i] = 32'h3F800000 + (32'(i) << 23);
        exp_op.push_back(32'h3F800000); exp_op.push_back(32'h40000000); exp_op.push_back(32'h40800000);
        add_q.push_back('{1'b0, 32'h40000000});
        add_q.push_back('{1'b0, 32'h40400000});
        add_q.push_back('{1'b1, 32'h00000000});
        add_q.push_back('{1'b0, 32'h40A00000});
        exp_wr.push_back('{8'd0, 32'h40000000});
        exp_wr.push_back('{8'd1, 32'h40400000});
        exp_wr.push_back('{8'd2, 32'h00000000});
        start_sweep(4);
        k = 0;
        @(negedge CLK);
        while (!spike_valid && k < 200) begin @(negedge CLK); k++; end
        chk("t5_in_spk", 32'({spike_valid, spike_id}), 32'h102);
        tick();
        RESET = 1'b1;
        #1;
        chk_idle_outputs("t5_async");
        tick();
        tick();
        chk_idle_outputs("t5_held");
        RESET = 1'b0;
        add_q.delete();
        chk_queues_empty("t5_flush");
        mem[0] = 32'h40A00000; mem[1] = 32'h40C00000;
        exp_op.push_back(32'h40A00000); exp_op.push_back(32'h40C00000);
        add_q.push_back('{1'b0, 32'h40C00000});
        add_q.push_back('{1'b0, 32'h40E00000});
        exp_wr.push_back('{8'd0, 32'h40C00000});
        exp_wr.push_back('{8'd1, 32'h40E00000});
        exp_done.push_back(1);
        rd_addrs.delete();
        start_sweep(2);
        wait_done("t5_done", 200);
        @(negedge CLK);
        chk("t5_rd_count", 32'(rd_addrs.size()), 32'd2);
        if (rd_addrs.size() != 0) chk("t5_first_idx", 32'(rd_addrs[0]), 32'd0);
        chk_queues_empty("t5");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
